// File: rtl/hwf_log_step_if.sv
// Operand/result bundle for the HWF log-step helper.
// The master drives the index and exponent operand.
// The slave returns the log constant and the subtraction result.
interface hwf_log_step_if #(
    parameter int unsigned XLEN_PIXEL = 8
);
    localparam int unsigned W = 2 * XLEN_PIXEL;

    logic signed [31:0] i;
    logic [W-1:0]       a;
    logic [W-1:0]       log_val;
    logic [W-1:0]       out;
    logic               neg;
    logic               ovf;

    modport master (
        output i,
        output a,
        input  log_val,
        input  out,
        input  neg,
        input  ovf
    );

    modport slave (
        input  i,
        input  a,
        output log_val,
        output out,
        output neg,
        output ovf
    );
endinterface

// File: rtl/hwf_log_step.sv
// HWF kernel helper: registered -ln(1 - 2^-i) lookup in 8.8 fixed point.
// A combinational subtractor produces Ei - log_val, its sign and its signed overflow.
module hwf_log_step #(
    parameter int unsigned XLEN_PIXEL = 8
) (
    input  logic           clk,
    input  logic           rst,
    hwf_log_step_if.slave  bus
);
    localparam int unsigned W = 2 * XLEN_PIXEL;

    // Table entries are 8.8 constants; any other word width is meaningless.
    if (XLEN_PIXEL != 8) begin : gen_bad_width
        $error("hwf_log_step: only XLEN_PIXEL == 8 is supported");
    end

    logic [W-1:0] table_val;
    logic [W-1:0] log_q;
    logic [W-1:0] diff;

    // Constant lookup; i <= 0 saturates because ln(0) is undefined.
    always_comb begin
        table_val = 16'h0000;
        if (bus.i <= 32'sd0) begin
            table_val = 16'h7FFF;
        end else begin
            case (bus.i)
                32'sd1:  table_val = 16'h00B1;
                32'sd2:  table_val = 16'h004A;
                32'sd3:  table_val = 16'h0022;
                32'sd4:  table_val = 16'h0011;
                32'sd5:  table_val = 16'h0008;
                32'sd6:  table_val = 16'h0004;
                32'sd7:  table_val = 16'h0002;
                32'sd8:  table_val = 16'h0001;
                32'sd9:  table_val = 16'h0001;
                default: table_val = 16'h0000;
            endcase
        end
    end

    // Lookup register: loads every edge, clears asynchronously on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            log_q <= '0;
        end else begin
            log_q <= table_val;
        end
    end

    // Wrapping subtraction; the sign is the kernel's per-iteration decision bit.
    always_comb begin
        diff = bus.a - log_q;
    end

    assign bus.log_val = log_q;
    assign bus.out     = diff;
    assign bus.neg     = diff[W-1];
    assign bus.ovf     = (bus.a[W-1] != log_q[W-1]) && (diff[W-1] != bus.a[W-1]);
endmodule

// File: tb/tb_hwf_log_step.sv
// Directed self-checking bench for hwf_log_step.
module tb_hwf_log_step;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    hwf_log_step_if #(.XLEN_PIXEL(8)) bus_if ();

    hwf_log_step #(.XLEN_PIXEL(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [15:0] sweep_exp [13];

    initial begin
        checks = 0;
        errors = 0;
        sweep_exp = '{16'h7FFF, 16'h00B1, 16'h004A, 16'h0022, 16'h0011, 16'h0008,
                      16'h0004, 16'h0002, 16'h0001, 16'h0001, 16'h0000, 16'h0000,
                      16'h0000};

        // Held in reset while the clock runs.
        rst      = 1'b0;
        bus_if.a = 16'h0300;
        bus_if.i = 3;
        repeat (3) @(posedge clk);
        #1;
        check("reset_log_val", bus_if.log_val, 16'h0000);
        check("reset_out",     bus_if.out,     16'h0300);
        check("reset_neg",     {15'd0, bus_if.neg}, 16'd0);
        check("reset_ovf",     {15'd0, bus_if.ovf}, 16'd0);

        // Table sweep, one cycle latency.
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            bus_if.i = k;
            @(posedge clk);
            #1;
            check($sformatf("table_i%0d", k), bus_if.log_val, sweep_exp[k]);
        end
        @(negedge clk);
        bus_if.i = -5;
        @(posedge clk);
        #1;
        check("table_neg5", bus_if.log_val, 16'h7FFF);

        // Positive result.
        @(negedge clk);
        bus_if.i = 1;
        bus_if.a = 16'h0200;
        @(posedge clk);
        #1;
        check("pos_out", bus_if.out, 16'h014F);
        check("pos_neg", {15'd0, bus_if.neg}, 16'd0);
        check("pos_ovf", {15'd0, bus_if.ovf}, 16'd0);

        // Negative result.
        @(negedge clk);
        bus_if.i = 2;
        bus_if.a = 16'h0010;
        @(posedge clk);
        #1;
        check("negres_out", bus_if.out, 16'hFFC6);
        check("negres_neg", {15'd0, bus_if.neg}, 16'd1);
        check("negres_ovf", {15'd0, bus_if.ovf}, 16'd0);

        // Overflow cases.
        @(negedge clk);
        bus_if.i = 1;
        bus_if.a = 16'h8000;
        @(posedge clk);
        #1;
        check("ovf1_out", bus_if.out, 16'h7F4F);
        check("ovf1_neg", {15'd0, bus_if.neg}, 16'd0);
        check("ovf1_ovf", {15'd0, bus_if.ovf}, 16'd1);
        @(negedge clk);
        bus_if.i = 0;
        @(posedge clk);
        #1;
        check("ovf0_out", bus_if.out, 16'h0001);
        check("ovf0_ovf", {15'd0, bus_if.ovf}, 16'd1);

        // Index change between edges has no effect until the next edge.
        @(negedge clk);
        bus_if.i = 1;
        bus_if.a = 16'h0123;
        @(posedge clk);
        #1;
        check("hold_pre", bus_if.log_val, 16'h00B1);
        #2;
        bus_if.i = 5;
        #1;
        check("hold_mid", bus_if.log_val, 16'h00B1);
        @(posedge clk);
        #1;
        check("hold_post", bus_if.log_val, 16'h0008);

        // Async reset between edges.
        @(negedge clk);
        bus_if.i = 1;
        @(posedge clk);
        #1;
        check("areset_pre", bus_if.log_val, 16'h00B1);
        #2;
        rst = 1'b0;
        #1;
        check("areset_log_val", bus_if.log_val, 16'h0000);
        check("areset_out",     bus_if.out,     16'h0123);
        check("areset_ovf",     {15'd0, bus_if.ovf}, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("areset_reload", bus_if.log_val, 16'h00B1);
        check("areset_out2",   bus_if.out,     16'h0072);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
